int_dispatch: RTL
=================

// Module: int_dispatch
// PURPOSE
//  Dispatch stage feeding int_rs: accepts renamed uops from rename over valid/ready and presents them
//  to int_rs over valid/ready with rs1_valid/rs2_valid resolved. Owns the physical-register busy table
//  (set when a producer dispatches, cleared by CDB broadcast). Forwards same-cycle CDB wakeups so
//  int_rs never misses a broadcast during its push cycle. One-entry registered output stage.
// PARAMETERS
//  PRF_DEPTH  64  number of physical registers; PRF_IDX = $clog2(PRF_DEPTH)
//  CDB_WIDTH  2   number of CDB broadcast ports snooped
//  ROB_IDX    5   rob_id width
// PORTS
//  clk             in   1        clock
//  rst             in   1        synchronous active-high reset
//  flush           in   1        pipeline flush (branch mispredict / exception)
//  ren_valid       in   1        rename has a uop
//  ren_ready       out  1        dispatch accepts uop this cycle
//  ren_uop         in   uop_t    pc, fu_opcode, op1_sel, op2_sel, rd_phy, rd_arch, rs1_phy, rs2_phy, imm, rob_id
//  rs_valid        out  1        uop presented to int_rs
//  rs_ready        in   1        int_rs has a free station
//  rs_uop          out  uop_t    held uop, rs1_valid/rs2_valid resolved
//  cdb_valid[k]    in   1        CDB port k broadcasting, k < CDB_WIDTH
//  cdb_rd_phy[k]   in   PRF_IDX  physical destination broadcast on port k
// BEHAVIOUR
//  Reset: out_valid=0 (rs_valid=0), rs_uop=0, busy[*]=0; ren_ready=1 after reset.
//  Handshake: ren_ready = !out_valid || rs_ready (combinational). Accept when ren_valid&&ren_ready;
//   hand-off when rs_valid&&rs_ready. Accept and hand-off in the same cycle -> back-to-back, no bubble.
//   Latency: uop accepted in cycle N is on rs_uop in cycle N+1. rs_uop held stable while rs_valid&&!rs_ready.
//  Operand resolution on accept (held_rsX_valid register):
//   op1_sel!=OP1_RS1 -> rs1_valid=1; else rs1_valid = !busy[rs1_phy] || any k: cdb_valid[k]&&cdb_rd_phy[k]==rs1_phy.
//   Same rule for rs2 with op2_sel/OP2_RS2. Busy is read BEFORE this uop's own rd set (rd_phy==rs1_phy sees old value).
//  While held: each cycle any CDB match on held rsX_phy sets held_rsX_valid.
//   Output rs_uop.rsX_valid = held_rsX_valid || same-cycle CDB match (combinational forward).
//  Busy table: on accept with rd_arch!=0 set busy[rd_phy]. CDB port k valid clears busy[cdb_rd_phy[k]].
//   Same reg set and cleared same cycle -> set wins. busy[0] is never set (x0 mapping).
//  Flush: next cycle out_valid=0, busy[*]=0, ren_uop ignored that cycle (ren_ready forced 0 during flush).
//   Flush has priority over accept, hand-off and CDB updates. Reset has priority over flush.
//  No internal FSM beyond out_valid; stall indefinitely on !rs_ready without loss or duplication.
// TESTING
//  1 reset, ren uop rs1=5 rs2=6 rd=7 OP1_RS1/OP2_RS2 -> next cycle rs_valid=1, rs1_valid=1, rs2_valid=1, busy[7]=1.
//  2 uop A rd=9, then uop B rs1=9 -> B rs1_valid=0; cdb_valid[1]=1 rd_phy=9 while B held, rs_ready=0 -> rs1_valid=1
//    same cycle, stays 1 after; busy[9]=0.
//  3 uop B rs1=9 (busy) accepted in cycle where cdb_valid[0]=1 rd_phy=9 -> B presented with rs1_valid=1.
//  4 rs_ready=0 for 5 cycles with ren_valid=1 -> ren_ready=0, rs_uop stable; rs_ready=1 then 3 uops
//    streamed back-to-back, each presented exactly once, in order.
//  5 uop rd_arch=0 rd_phy=0 -> busy[0] stays 0; uop rs1=rd=12 -> rs1_valid from old busy[12]; set/clear same cycle on 12 -> busy[12]=1.
//  6 flush with out_valid=1, busy[3]=busy[4]=1 -> next cycle rs_valid=0, all busy 0; ren_valid during flush not accepted.

Source files
------------

// File: rtl/int_dispatch.sv
// int_dispatch: dispatch stage between rename and int_rs.
//   Takes renamed uops from rename over valid/ready. Each uop is held in a one-entry
//   registered output stage and shown to int_rs with rs1_valid/rs2_valid already resolved.
//   The block owns the physical-register busy table. A producer sets its destination bit
//   when it dispatches, and a CDB broadcast clears it. Same-cycle CDB wakeups are forwarded
//   onto the output so int_rs never misses a broadcast during its push cycle.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             pipeline flush; drops the held uop and clears the busy table
//   ren_valid/ready   rename handshake; ren_uop carries the packed uop (layout below)
//   rs_valid/ready    int_rs handshake; rs_uop carries the held uop with operand valids
//   cdb_valid         one bit per CDB port
//   cdb_rd_phy        port k destination at [k*PRF_IDX +: PRF_IDX]
// Packed uop layout (MSB first): pc[31:0], fu_opcode[3:0], op1_sel[1:0], op2_sel[1:0],
//   rd_phy, rd_arch[4:0], rs1_phy, rs2_phy, imm[31:0], rob_id, rs1_valid, rs2_valid.
//   The rs1_valid/rs2_valid bits of ren_uop are ignored.
module int_dispatch #(
  parameter  int PRF_DEPTH = 64,
  parameter  int CDB_WIDTH = 2,
  parameter  int ROB_IDX   = 5,
  localparam int PRF_IDX   = $clog2(PRF_DEPTH),
  localparam int UOP_W     = 32 + 4 + 2 + 2 + PRF_IDX + 5 + PRF_IDX + PRF_IDX + 32 + ROB_IDX + 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         ren_valid,
  output logic                         ren_ready,
  input  logic [UOP_W-1:0]             ren_uop,
  output logic                         rs_valid,
  input  logic                         rs_ready,
  output logic [UOP_W-1:0]             rs_uop,
  input  logic [CDB_WIDTH-1:0]         cdb_valid,
  input  logic [CDB_WIDTH*PRF_IDX-1:0] cdb_rd_phy
);

  typedef enum logic [1:0] {
    OP1_RS1  = 2'd0,
    OP1_PC   = 2'd1,
    OP1_ZERO = 2'd2
  } op1_sel_e;

  typedef enum logic [1:0] {
    OP2_RS2  = 2'd0,
    OP2_IMM  = 2'd1,
    OP2_ZERO = 2'd2
  } op2_sel_e;

  typedef struct packed {
    logic [31:0]        pc;
    logic [3:0]         fu_opcode;
    op1_sel_e           op1_sel;
    op2_sel_e           op2_sel;
    logic [PRF_IDX-1:0] rd_phy;
    logic [4:0]         rd_arch;
    logic [PRF_IDX-1:0] rs1_phy;
    logic [PRF_IDX-1:0] rs2_phy;
    logic [31:0]        imm;
    logic [ROB_IDX-1:0] rob_id;
    logic               rs1_valid;
    logic               rs2_valid;
  } uop_t;

  uop_t                 in_uop;
  uop_t                 out_uop;
  uop_t                 held_q, held_d;
  logic                 out_valid_q, out_valid_d;
  logic [PRF_DEPTH-1:0] busy_q, busy_d;
  logic                 accept;
  logic                 handoff;
  logic                 in_rs1_hit, in_rs2_hit;
  logic                 held_rs1_hit, held_rs2_hit;

  function automatic logic cdb_hit(
    input logic [PRF_IDX-1:0]           phy,
    input logic [CDB_WIDTH-1:0]         v,
    input logic [CDB_WIDTH*PRF_IDX-1:0] rd
  );
    logic hit;
    hit = 1'b0;
    for (int unsigned k = 0; k < CDB_WIDTH; k++) begin
      if (v[k] && (rd[k*PRF_IDX +: PRF_IDX] == phy)) hit = 1'b1;
    end
    return hit;
  endfunction

  always_comb begin
    in_uop       = uop_t'(ren_uop);
    ren_ready    = !flush && (!out_valid_q || rs_ready);
    accept       = ren_valid && ren_ready;
    handoff      = out_valid_q && rs_ready;

    in_rs1_hit   = cdb_hit(in_uop.rs1_phy, cdb_valid, cdb_rd_phy);
    in_rs2_hit   = cdb_hit(in_uop.rs2_phy, cdb_valid, cdb_rd_phy);
    held_rs1_hit = cdb_hit(held_q.rs1_phy, cdb_valid, cdb_rd_phy);
    held_rs2_hit = cdb_hit(held_q.rs2_phy, cdb_valid, cdb_rd_phy);

    // The held valid bits plus any wakeup broadcast in this same cycle.
    out_uop           = held_q;
    out_uop.rs1_valid = held_q.rs1_valid || (out_valid_q && held_rs1_hit);
    out_uop.rs2_valid = held_q.rs2_valid || (out_valid_q && held_rs2_hit);

    rs_valid = out_valid_q;
    rs_uop   = out_uop;

    out_valid_d = out_valid_q;
    held_d      = held_q;
    busy_d      = busy_q;

    if (flush) begin
      out_valid_d = 1'b0;
      busy_d      = '0;
    end else begin
      if (accept) begin
        out_valid_d      = 1'b1;
        held_d           = in_uop;
        // busy_q is the value before this uop's own rd is set, so rd == rs sees the old bit.
        held_d.rs1_valid = (in_uop.op1_sel != OP1_RS1) || !busy_q[in_uop.rs1_phy] || in_rs1_hit;
        held_d.rs2_valid = (in_uop.op2_sel != OP2_RS2) || !busy_q[in_uop.rs2_phy] || in_rs2_hit;
      end else if (handoff) begin
        out_valid_d = 1'b0;
      end else if (out_valid_q) begin
        held_d.rs1_valid = out_uop.rs1_valid;
        held_d.rs2_valid = out_uop.rs2_valid;
      end

      for (int unsigned k = 0; k < CDB_WIDTH; k++) begin
        if (cdb_valid[k]) busy_d[cdb_rd_phy[k*PRF_IDX +: PRF_IDX]] = 1'b0;
      end
      // The set is applied after the clears so that it wins. x0 is never marked busy.
      if (accept && (in_uop.rd_arch != 5'd0) && (in_uop.rd_phy != '0)) begin
        busy_d[in_uop.rd_phy] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      held_q      <= '0;
      busy_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      held_q      <= held_d;
      busy_q      <= busy_d;
    end
  end

endmodule
